fib_pair_serializer: RTL and testbench
======================================

// Module: fib_pair_serializer
// PURPOSE
//  Downstream stage of the double-rate Fibonacci generator. Accepts one pair of
//  numbers per beat (num, then num2), emits them one per beat, in order, on a
//  valid/ready stream. Tags each output with a running index. Raises a sticky
//  flag when a WIDTH-bit wrap-around is detected in the monotonic sequence.
// PARAMETERS
//  WIDTH  16  data width of each number
//  IDX_W  8   width of out_index; wraps modulo 2**IDX_W
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      pair on in_num/in_num2 is valid
//  in_ready   out  1      pair accepted when in_valid && in_ready
//  in_num     in   WIDTH  first (older) number of pair
//  in_num2    in   WIDTH  second (newer) number of pair
//  out_valid  out  1      out_data valid
//  out_ready  in   1      sink accepts when out_valid && out_ready
//  out_data   out  WIDTH  current number
//  out_index  out  IDX_W  sequence index of out_data (0-based)
//  wrap_seen  out  1      sticky: some emitted value < previous emitted value
// BEHAVIOUR
//  - Reset (rst, synchronous, active-high; clock clk): state EMPTY, hold0/hold1 = 0,
//    out_valid=0, out_data=0, out_index=0, wrap_seen=0, last value reg=0, first_done=0.
//  - FSM states: EMPTY, HAVE_TWO (presenting hold0), HAVE_ONE (presenting hold1).
//  - in_ready = (state==EMPTY) | (state==HAVE_ONE & out_ready). Combinational.
//  - out_valid = (state!=EMPTY); out_data = HAVE_TWO ? hold0 : hold1 (0 in EMPTY).
//  - Transitions:
//    EMPTY:    in_valid -> load hold0=in_num, hold1=in_num2, go HAVE_TWO.
//    HAVE_TWO: out_ready -> HAVE_ONE; else hold.
//    HAVE_ONE: out_ready & in_valid -> load new pair, HAVE_TWO (no bubble);
//              out_ready & !in_valid -> EMPTY; !out_ready -> hold.
//  - Latency: pair accepted in cycle N -> first number valid at N+1, second at N+2
//    minimum. Max throughput: 1 pair / 2 cycles, 1 number / cycle, sustained.
//  - Output data/valid stable while out_valid & !out_ready (no change until taken).
//  - On each output handshake: out_index <= out_index+1 (mod 2**IDX_W);
//    last <= out_data; first_done <= 1; if first_done & out_data < last ->
//    wrap_seen <= 1. wrap_seen cleared only by rst.
//  - Comparison unsigned, WIDTH bits; equal values (1,1) do not set wrap_seen.
//  - in_valid while in_ready=0: pair ignored, upstream must hold it.
//  - rst mid-stream: buffered pair discarded, all state to reset values next edge.
// STRUCTURE
//  - fib_pkg: typedef enum logic [1:0] {EMPTY, HAVE_TWO, HAVE_ONE} ser_state_t;
//    localparam FIB_WIDTH = 16 (default for WIDTH).
//  - Single module; no sub-module. Index/wrap tracker kept inline (~20 lines).
// TESTING
//  1 Reset then idle: out_valid=0, in_ready=1, out_index=0, wrap_seen=0.
//  2 Pairs (1,1),(2,3),(5,8) back-to-back, out_ready=1 -> out_data 1,1,2,3,5,8
//    on consecutive cycles, out_index 0..5, in_ready toggles 1,0,1,0...
//  3 Backpressure: out_ready=0 for 3 cycles on HAVE_TWO with pair (13,21) ->
//    out_data holds 13, in_ready=0; release -> 13,21 emitted, index continues.
//  4 Wrap: feed true Fibonacci pairs from (1,1) through (46368,75025 mod 65536=9489)
//    -> wrap_seen rises on handshake of index 24 (9489 < 46368), stays 1.
//  5 Index wrap: 256 handshakes with IDX_W=8 -> out_index returns to 0.
//  6 rst asserted in HAVE_ONE with (34,55) buffered -> next cycle out_valid=0,
//    out_index=0, wrap_seen=0; 55 never emitted.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types for the double-rate Fibonacci generator.
// Serializer state encoding and default widths.
package fib_pkg;

  localparam int FIB_WIDTH = 16;
  localparam int FIB_IDX_W = 8;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    HAVE_TWO = 2'd1,
    HAVE_ONE = 2'd2
  } ser_state_t;

endpackage

// File: rtl/fib_pair_serializer_if.sv
// Pair-in / number-out stream bundle for the serializer.
// slave = the serializer, master = upstream source plus downstream sink.
interface fib_pair_serializer_if
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int IDX_W = FIB_IDX_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_num2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic             wrap_seen;

  modport slave (
    input  in_valid,
    input  in_num,
    input  in_num2,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_index,
    output wrap_seen
  );

  modport master (
    output in_valid,
    output in_num,
    output in_num2,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_index,
    input  wrap_seen
  );

endinterface

// File: rtl/fib_pair_serializer.sv
// Splits Fibonacci pairs into a one-number-per-beat stream,
// tagging each number with an index and flagging wrap-around.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int IDX_W = FIB_IDX_W
) (
  input logic                  clk,
  input logic                  rst,
  fib_pair_serializer_if.slave bus
);

  ser_state_t       state;
  logic [WIDTH-1:0] hold0;
  logic [WIDTH-1:0] hold1;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] last_q;
  logic             first_done;
  logic             wrap_q;

  logic             in_ready_c;
  logic             take_out;

  assign in_ready_c = (state == EMPTY) |
                      ((state == HAVE_ONE) & bus.out_ready);
  assign take_out   = valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_index = idx_q;
  assign bus.wrap_seen = wrap_q;

  // Pair buffer FSM; the presented number is registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      hold0   <= '0;
      hold1   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (bus.in_valid) begin
            hold0   <= bus.in_num;
            hold1   <= bus.in_num2;
            data_q  <= bus.in_num;
            valid_q <= 1'b1;
            state   <= HAVE_TWO;
          end
        end
        HAVE_TWO: begin
          if (bus.out_ready) begin
            data_q <= hold1;
            state  <= HAVE_ONE;
          end
        end
        HAVE_ONE: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              hold0  <= bus.in_num;
              hold1  <= bus.in_num2;
              data_q <= bus.in_num;
              state  <= HAVE_TWO;
            end else begin
              data_q  <= '0;
              valid_q <= 1'b0;
              state   <= EMPTY;
            end
          end
        end
        default: begin
          data_q  <= '0;
          valid_q <= 1'b0;
          state   <= EMPTY;
        end
      endcase
    end
  end

  // Index counter and sticky wrap detector, advanced per output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      last_q     <= '0;
      first_done <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (take_out) begin
      idx_q      <= idx_q + IDX_W'(1);
      last_q     <= data_q;
      first_done <= 1'b1;
      if (first_done && (data_q < last_q))
        wrap_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Scoreboard bench for fib_pair_serializer.
// Directed pairs in, monitor pops and compares each output beat.
module tb_fib_pair_serializer;
  import fib_pkg::*;

  localparam int W  = 16;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fib_pair_serializer_if #(.WIDTH(W), .IDX_W(IW)) bus ();

  fib_pair_serializer #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          wrap;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [IW-1:0] exp_idx;
  int            waits;
  int            fib[0:25];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got data %0d idx %0d expected none",
                 bus.out_data, bus.out_index);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", bus.out_data, mon_e.data);
        chk("out_index", bus.out_index, mon_e.idx);
        chk("wrap_before", bus.wrap_seen, mon_e.wrap);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic wa, input logic wb,
                           output int nw);
    bit done;
    done = 0;
    nw = 0;
    bus.in_valid = 1'b1;
    bus.in_num   = a;
    bus.in_num2  = b;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      nw++;
      if (bus.in_ready) begin
        sb.push_back('{data: a, idx: exp_idx, wrap: wa});
        sb.push_back('{data: b, idx: IW'(exp_idx + 1), wrap: wb});
        exp_idx = IW'(exp_idx + 2);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept of %0d", a);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_num2   = '0;
    bus.out_ready = 1'b0;

    // 1: reset then idle
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_wrap_seen", bus.wrap_seen, 0);
    chk("rst_out_data", bus.out_data, 0);
    @(posedge clk);
    #1;

    // 2: back-to-back pairs at full rate
    bus.out_ready = 1'b1;
    send_pair(16'd1, 16'd1, 1'b0, 1'b0, waits);
    chk("b2b_wait0", waits, 1);
    send_pair(16'd2, 16'd3, 1'b0, 1'b0, waits);
    chk("b2b_wait1", waits, 2);
    send_pair(16'd5, 16'd8, 1'b0, 1'b0, waits);
    chk("b2b_wait2", waits, 2);
    drain();

    // 3: backpressure on HAVE_TWO, with an ignored pair offered
    bus.out_ready = 1'b0;
    send_pair(16'd13, 16'd21, 1'b0, 1'b0, waits);
    chk("bp_wait", waits, 1);
    bus.in_valid = 1'b1;
    bus.in_num   = 16'd99;
    bus.in_num2  = 16'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, 13);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("bp_index_after", bus.out_index, 8);

    // 4: true Fibonacci with 16-bit wrap at index 24
    do_reset();
    bus.out_ready = 1'b1;
    fib[0] = 1;
    fib[1] = 1;
    for (int k = 2; k < 26; k++) fib[k] = fib[k-1] + fib[k-2];
    for (int j = 0; j < 13; j++) begin
      send_pair(W'(fib[2*j]), W'(fib[2*j+1]),
                (2*j) > 24, (2*j+1) > 24, waits);
      if (j == 11) begin
        drain();
        chk("wrap_pre", bus.wrap_seen, 0);
      end
    end
    drain();
    chk("wrap_post", bus.wrap_seen, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_sticky", bus.wrap_seen, 1);

    // 6: reset while HAVE_ONE holds 55
    send_pair(16'd34, 16'd55, 1'b1, 1'b1, waits);
    @(posedge clk);
    #1;
    chk("h1_valid", bus.out_valid, 1);
    chk("h1_data", bus.out_data, 55);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_idx = '0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_index", bus.out_index, 0);
    chk("mid_rst_wrap", bus.wrap_seen, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_idle", bus.out_valid, 0);

    // 5: 256 handshakes wrap the index back to 0
    for (int j = 0; j < 128; j++)
      send_pair(W'(2*j), W'(2*j+1), 1'b0, 1'b0, waits);
    drain();
    chk("idx_wrap", bus.out_index, 0);
    chk("idx_wrap_flag", bus.wrap_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
